// File: rtl/constraint_gen_pkg.sv
// Shared types and constants for the constraint solution generator.
//   gen_state_t : FSM state encoding (IDLE / GEN / HOLD)
//   LFSR_W      : candidate / LFSR width
//   CNT_W       : run-length and reject counter width
//   lfsr_next() : one Fibonacci step of x^15 + x^14 + 1
package constraint_gen_pkg;

  localparam int LFSR_W = 15;
  localparam int CNT_W  = 16;

  // Feedback taps (bit indices) for x^15 + x^14 + 1
  localparam int TAP_HI = 14;
  localparam int TAP_LO = 13;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_HOLD = 2'd2
  } gen_state_t;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/constraint_solution_gen_lfsr15.sv
// 15-bit Fibonacci LFSR (x^15 + x^14 + 1), period 32767.
//   clk, rst_n : clock, async active-low reset (resets to SEED)
//   load       : load load_val (takes priority over step)
//   load_val   : value to load; caller guarantees nonzero
//   step       : advance one position
//   state      : current LFSR contents
module lfsr15
  import constraint_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 15'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);

  logic [LFSR_W-1:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    r_state <= SEED;
    else if (load) r_state <= load_val;
    else if (step) r_state <= lfsr_next(r_state);
  end

  assign state = r_state;

endmodule

// File: rtl/constraint_solution_gen.sv
// Candidate assignment source for var_54: walks an LFSR, drops the single
// forbidden value EXCLUDED, and hands each surviving value out on a
// valid/ready stream. A run emits `count` values, then pulses done.
//
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   seed_load, seed_in  : reseed the LFSR in IDLE (zero seed -> SEED)
//   start, count        : start a run of `count` solutions (IDLE only)
//   abort               : drop back to IDLE immediately, no done pulse
//   out_valid/out_ready : output handshake, out_data holds the solution
//   busy                : run in progress (GEN or HOLD)
//   done                : one-cycle pulse at run completion
//   reject_cnt          : candidates rejected this/last run (saturating)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; seed loads accepted
// GEN   | test current LFSR value, advance LFSR; reject or capture it
// HOLD  | out_valid high, LFSR frozen, waiting for out_ready
module constraint_solution_gen
  import constraint_gen_pkg::*;
#(
  parameter logic [LFSR_W-1:0] EXCLUDED = 15'h1bde,
  parameter logic [LFSR_W-1:0] SEED     = 15'h0001
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  count,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  reject_cnt
);

  gen_state_t        r_state;
  gen_state_t        w_next_state;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_out_valid;
  logic [LFSR_W-1:0] r_out_data;
  logic              r_busy;
  logic              r_done;
  logic [CNT_W-1:0]  r_reject_cnt;

  logic [LFSR_W-1:0] w_lfsr_state;
  logic [LFSR_W-1:0] w_seed_val;
  logic              w_lfsr_load;
  logic              w_lfsr_step;
  logic              w_run_start;
  logic              w_zero_run;
  logic              w_reject;
  logic              w_accept;
  logic              w_handshake;
  logic              w_last;

  assign w_seed_val = (seed_in == '0) ? SEED : seed_in;

  lfsr15 #(.SEED(SEED)) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_lfsr_load),
    .load_val (w_seed_val),
    .step     (w_lfsr_step),
    .state    (w_lfsr_state)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  // abort overrides everything, so all strobes stay low when it is asserted
  always_comb begin
    w_next_state = r_state;
    w_lfsr_load  = 1'b0;
    w_lfsr_step  = 1'b0;
    w_run_start  = 1'b0;
    w_zero_run   = 1'b0;
    w_reject     = 1'b0;
    w_accept     = 1'b0;
    w_handshake  = 1'b0;
    w_last       = 1'b0;
    if (abort) begin
      w_next_state = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_lfsr_load = seed_load;
          if (start) begin
            if (count != '0) begin
              w_run_start  = 1'b1;
              w_next_state = ST_GEN;
            end else begin
              w_zero_run = 1'b1;
            end
          end
        end
        ST_GEN: begin
          w_lfsr_step = 1'b1;
          if (w_lfsr_state == EXCLUDED) begin
            w_reject = 1'b1;
          end else begin
            w_accept     = 1'b1;
            w_next_state = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_out_valid && out_ready) begin
            w_handshake = 1'b1;
            if (r_remaining == CNT_W'(1)) begin
              w_last       = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_next_state = ST_GEN;
            end
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_remaining  <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_reject_cnt <= '0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= w_zero_run | w_last;

      if (abort)            r_remaining <= '0;
      else if (w_run_start) r_remaining <= count;
      else if (w_handshake) r_remaining <= r_remaining - CNT_W'(1);

      if (abort || w_handshake) r_out_valid <= 1'b0;
      else if (w_accept)        r_out_valid <= 1'b1;

      if (w_accept) r_out_data <= w_lfsr_state;

      if (w_run_start || w_zero_run)
        r_reject_cnt <= '0;
      else if (w_reject && (r_reject_cnt != '1))
        r_reject_cnt <= r_reject_cnt + CNT_W'(1);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign busy       = r_busy;
  assign done       = r_done;
  assign reject_cnt = r_reject_cnt;

endmodule

// File: tb/tb_constraint_solution_gen.sv
// Self-checking bench for constraint_solution_gen: a reference LFSR model
// pushes expected solutions into a queue; a monitor pops and compares on
// every handshake. Directed checks cover latency, stalls, abort and
// zero-length runs.
module tb_constraint_solution_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        seed_load = 1'b0;
  logic [14:0] seed_in = '0;
  logic        start = 1'b0;
  logic [15:0] count = '0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [14:0] out_data;
  logic        busy;
  logic        done;
  logic [15:0] reject_cnt;

  constraint_solution_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .seed_load  (seed_load),
    .seed_in    (seed_in),
    .start      (start),
    .count      (count),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .reject_cnt (reject_cnt)
  );

  always #5 clk = ~clk;

  localparam logic [14:0] EXC = 15'h1bde;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_edge = 0;
  logic [14:0] m_lfsr = 15'h0001;
  int          m_rej = 0;
  logic [14:0] exp_q[$];

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] nx(input logic [14:0] s);
    return {s[13:0], s[14] ^ s[13]};
  endfunction

  // Model n accepted solutions: skip the excluded value, step after each test
  task automatic model_run(input int n);
    m_rej = 0;
    for (int i = 0; i < n; i++) begin
      while (m_lfsr == EXC) begin
        m_lfsr = nx(m_lfsr);
        m_rej++;
      end
      exp_q.push_back(m_lfsr);
      m_lfsr = nx(m_lfsr);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("unexpected_output", 32'(out_data), 32'hffff_ffff);
      else                   check("out_data", 32'(out_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic do_start(input logic [15:0] cnt, input logic ld, input logic [14:0] sd);
    @(posedge clk); #1;
    start = 1'b1; count = cnt; seed_load = ld; seed_in = sd;
    @(posedge clk); #1;
    n_edge = cyc;
    start = 1'b0; seed_load = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int rel);
    rel = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid) begin
        rel = cyc - n_edge;
        break;
      end
    end
    if (rel < 0) check("valid_timeout", 0, 1);
  endtask

  task automatic wait_done(input int max, output int rel);
    rel = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (done) begin
        rel = cyc - n_edge;
        check("busy_at_done", 32'(busy), 0);
        break;
      end
    end
    if (rel < 0) check("done_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int rel;
    logic [14:0] held;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_reject_cnt", 32'(reject_cnt), 0);
    rst_n = 1'b1;

    // Basic run of 3 from the reset seed, full throughput
    out_ready = 1'b1;
    model_run(3);
    do_start(16'd3, 1'b0, '0);
    @(negedge clk);
    check("t1_busy_n1", 32'(busy), 1);
    check("t1_valid_n1", 32'(out_valid), 0);
    wait_valid(10, rel);
    check("t1_first_valid_lat", 32'(rel), 1);
    wait_done(20, rel);
    check("t1_done_lat", 32'(rel), 6);
    check("t1_reject_cnt", 32'(reject_cnt), 0);
    @(negedge clk);
    check("t1_done_one_cycle", 32'(done), 0);
    check("t1_queue_empty", 32'(exp_q.size()), 0);

    // Seed at the excluded value together with start: one rejection
    m_lfsr = EXC;
    model_run(1);
    do_start(16'd1, 1'b1, EXC);
    wait_valid(10, rel);
    check("t2_first_valid_lat", 32'(rel), 2);
    check("t2_out_data", 32'(out_data), 32'h37bc);
    wait_done(10, rel);
    check("t2_reject_cnt", 32'(reject_cnt), 32'(m_rej));

    // Back-pressure: 5 stalled cycles in HOLD
    out_ready = 1'b0;
    model_run(2);
    do_start(16'd2, 1'b0, '0);
    wait_valid(10, rel);
    held = exp_q[0];
    for (int i = 0; i < 5; i++) begin
      check("t3_stall_valid", 32'(out_valid), 1);
      check("t3_stall_data", 32'(out_data), 32'(held));
      @(negedge clk);
    end
    out_ready = 1'b1;
    wait_done(20, rel);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // Abort while holding an output
    out_ready = 1'b0;
    model_run(1);
    do_start(16'd3, 1'b0, '0);
    wait_valid(10, rel);
    check("t4_hold_data", 32'(out_data), 32'(exp_q.pop_front()));
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t4_abort_valid", 32'(out_valid), 0);
      check("t4_abort_busy", 32'(busy), 0);
      check("t4_abort_done", 32'(done), 0);
    end
    out_ready = 1'b1;
    model_run(1);
    do_start(16'd1, 1'b0, '0);
    wait_done(20, rel);
    check("t4_queue_empty", 32'(exp_q.size()), 0);

    // Zero-length run
    do_start(16'd0, 1'b0, '0);
    @(negedge clk);
    check("t5_zero_done", 32'(done), 1);
    check("t5_zero_busy", 32'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_zero_valid", 32'(out_valid), 0);
      check("t5_zero_done_once", 32'(done), 0);
    end

    // start while busy is ignored
    out_ready = 1'b0;
    model_run(2);
    do_start(16'd2, 1'b0, '0);
    wait_valid(10, rel);
    @(posedge clk); #1 start = 1'b1; count = 16'd5;
    @(posedge clk); #1 start = 1'b0;
    out_ready = 1'b1;
    wait_done(20, rel);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_idle_after_done", 32'(out_valid | busy), 0);
    end
    check("t6_queue_empty", 32'(exp_q.size()), 0);

    // Zero seed falls back to the default seed
    @(posedge clk); #1 seed_load = 1'b1; seed_in = '0;
    @(posedge clk); #1 seed_load = 1'b0;
    m_lfsr = 15'h0001;
    model_run(1);
    do_start(16'd1, 1'b0, '0);
    wait_valid(10, rel);
    check("t7_zero_seed_data", 32'(out_data), 32'h0001);
    wait_done(10, rel);
    check("t7_queue_empty", 32'(exp_q.size()), 0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
